// File: rtl/alu_op_sequencer.sv
// ALU control decoder feeding a small micro-op FIFO; slt is split into a
// subtract followed by a set-on-sign, emitted by a two-state FSM.
module alu_op_sequencer #(
  parameter int FUNC_W = 4,
  parameter int OP_W   = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUop,
  input  logic [FUNC_W-1:0] func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   op,
  output logic              op_last,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SET = OP_W'(7);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t            state_q, state_d;
  logic [OP_W:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]  ill_q, ill_d;

  logic              full, empty;
  logic              accept, pop, push;
  logic [OP_W:0]     push_data;
  logic [8:0]        func_ext;
  logic              is_slt, is_ill;

  function automatic logic [OP_W-1:0] decode_op(input logic [1:0] aluop,
                                                 input logic [8:0] f);
    logic [OP_W-1:0] r;
    r = '1;
    case (aluop)
      2'd0: r = OP_W'(2);
      2'd1: r = OP_W'(3);
      2'd3: r = OP_W'(4);
      default: begin
        case (f)
          9'd0:    r = OP_W'(2);
          9'd1:    r = OP_W'(3);
          9'd2:    r = OP_W'(0);
          9'd3:    r = OP_W'(4);
          9'd4:    r = OP_W'(5);
          9'd5:    r = OP_W'(1);
          9'd6:    r = OP_W'(6);
          9'd7:    r = OP_SUB;
          default: r = '1;
        endcase
      end
    endcase
    return r;
  endfunction

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign func_ext = 9'(func);
  assign is_slt   = (ALUop == 2'd2) && (func_ext == 9'd7);
  assign is_ill   = (ALUop == 2'd2) && (func_ext >= 9'd8);

  // rst_n gates in_ready so nothing is offered while reset is held
  assign in_ready = rst_n && (state_q == IDLE) && !full;
  assign accept   = in_valid && in_ready;
  assign pop      = !empty && out_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_slt) state_d = SECOND;
      SECOND:  if (!full)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: what gets pushed into the queue this cycle
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          push      = 1'b1;
          push_data = is_slt ? {OP_SUB, 1'b0} : {decode_op(ALUop, func_ext), 1'b1};
        end
      end
      SECOND: begin
        if (!full) begin
          push      = 1'b1;
          push_data = {OP_SET, 1'b1};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop  ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    ill_d = ill_q;
    if (accept && is_ill && (ill_q != '1)) ill_d = ill_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ill_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ill_q <= ill_d;
    end
  end

  // Storage is not reset; the head is masked to zero whenever the queue is empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  assign out_valid   = !empty;
  assign op          = empty ? '0   : mem_q[rd_q][OP_W:1];
  assign op_last     = empty ? 1'b0 : mem_q[rd_q][0];
  assign illegal_cnt = ill_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: decode table plus hand-written
// backpressure, slt, illegal-func and reset sequences.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] ALUop;
  logic [4:0] func;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] op;
  logic       op_last;
  logic [1:0] illegal_cnt;

  int total;
  int passed;

  alu_op_sequencer #(.FUNC_W(5), .OP_W(4), .DEPTH(4), .CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUop      (ALUop),
    .func       (func),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .op         (op),
    .op_last    (op_last),
    .illegal_cnt(illegal_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] aluop;
    logic [4:0] fn;
    logic [3:0] exp_op;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] bp_exp [4];
    logic [3:0] nf_exp [4];
    logic       nf_last [4];
    logic [1:0] ill_exp [5];

    total  = 0;
    passed = 0;

    vecs[0]  = '{2'd0, 5'd0, 4'd2};
    vecs[1]  = '{2'd1, 5'd0, 4'd3};
    vecs[2]  = '{2'd3, 5'd0, 4'd4};
    vecs[3]  = '{2'd2, 5'd0, 4'd2};
    vecs[4]  = '{2'd2, 5'd1, 4'd3};
    vecs[5]  = '{2'd2, 5'd2, 4'd0};
    vecs[6]  = '{2'd2, 5'd3, 4'd4};
    vecs[7]  = '{2'd2, 5'd4, 4'd5};
    vecs[8]  = '{2'd2, 5'd5, 4'd1};
    vecs[9]  = '{2'd2, 5'd6, 4'd6};
    vecs[10] = '{2'd0, 5'd7, 4'd2};

    rst_n = 1'b0; in_valid = 1'b0; ALUop = 2'd0; func = 5'd0; out_ready = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst op", 32'(op), 0);
    check("rst op_last", 32'(op_last), 0);
    check("rst in_ready", 32'(in_ready), 0);
    check("rst illegal_cnt", 32'(illegal_cnt), 0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("post-rst in_ready", 32'(in_ready), 1);

    // full decode, one request per cycle with out_ready=1
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; ALUop = vecs[i].aluop; func = vecs[i].fn;
      check($sformatf("dec[%0d] in_ready", i), 32'(in_ready), 1);
      tick();
      check($sformatf("dec[%0d] out_valid", i), 32'(out_valid), 1);
      check($sformatf("dec[%0d] op", i), 32'(op), 32'(vecs[i].exp_op));
      check($sformatf("dec[%0d] op_last", i), 32'(op_last), 1);
    end
    in_valid = 1'b0;
    tick();
    check("dec drained", 32'(out_valid), 0);

    // slt split with consumer ready
    in_valid = 1'b1; ALUop = 2'd2; func = 5'd7;
    tick();
    in_valid = 1'b0;
    check("slt first op", 32'(op), 3);
    check("slt first last", 32'(op_last), 0);
    check("slt in_ready low", 32'(in_ready), 0);
    tick();
    check("slt second op", 32'(op), 7);
    check("slt second last", 32'(op_last), 1);
    check("slt in_ready back", 32'(in_ready), 1);
    tick();
    check("slt drained", 32'(out_valid), 0);

    // backpressure: fill four entries, try a fifth, then drain
    bp_exp[0] = 4'd2; bp_exp[1] = 4'd3; bp_exp[2] = 4'd4; bp_exp[3] = 4'd6;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      ALUop = (i == 0) ? 2'd0 : (i == 1) ? 2'd1 : (i == 2) ? 2'd3 : 2'd2;
      func  = 5'd6;
      check($sformatf("bp fill[%0d] in_ready", i), 32'(in_ready), 1);
      tick();
    end
    check("bp full in_ready", 32'(in_ready), 0);
    in_valid = 1'b1; ALUop = 2'd1; func = 5'd0;
    tick();
    in_valid = 1'b0;
    check("bp ignored head", 32'(op), 2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp drain[%0d] op", i), 32'(op), 32'(bp_exp[i]));
      check($sformatf("bp drain[%0d] last", i), 32'(op_last), 1);
      tick();
      if (i == 0) check("bp in_ready returns", 32'(in_ready), 1);
    end
    check("bp empty", 32'(out_valid), 0);

    // slt arriving with three entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      ALUop = (i == 0) ? 2'd0 : (i == 1) ? 2'd1 : 2'd3;
      func  = 5'd0;
      tick();
    end
    ALUop = 2'd2; func = 5'd7;
    check("nf slt in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("nf held in_ready", 32'(in_ready), 0);
    check("nf held head", 32'(op), 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("nf after pop head", 32'(op), 3);
    check("nf after pop in_ready", 32'(in_ready), 0);
    tick();
    check("nf after push in_ready", 32'(in_ready), 0);
    nf_exp[0] = 4'd3; nf_last[0] = 1'b1;
    nf_exp[1] = 4'd4; nf_last[1] = 1'b1;
    nf_exp[2] = 4'd3; nf_last[2] = 1'b0;
    nf_exp[3] = 4'd7; nf_last[3] = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("nf drain[%0d] valid", i), 32'(out_valid), 1);
      check($sformatf("nf drain[%0d] op", i), 32'(op), 32'(nf_exp[i]));
      check($sformatf("nf drain[%0d] last", i), 32'(op_last), 32'(nf_last[i]));
      tick();
    end
    check("nf empty", 32'(out_valid), 0);
    check("nf in_ready", 32'(in_ready), 1);

    // illegal func, saturating 2-bit counter
    ill_exp[0] = 2'd1; ill_exp[1] = 2'd2; ill_exp[2] = 2'd3; ill_exp[3] = 2'd3; ill_exp[4] = 2'd3;
    check("ill cnt start", 32'(illegal_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; ALUop = 2'd2; func = 5'd8;
      tick();
      check($sformatf("ill[%0d] op", i), 32'(op), 32'hF);
      check($sformatf("ill[%0d] last", i), 32'(op_last), 1);
      check($sformatf("ill[%0d] cnt", i), 32'(illegal_cnt), 32'(ill_exp[i]));
    end
    in_valid = 1'b0;
    tick();

    // reset while the second half of slt is pending
    in_valid = 1'b1; ALUop = 2'd2; func = 5'd7;
    tick();
    in_valid = 1'b0;
    check("rs slt first", 32'(op), 3);
    #1 rst_n = 1'b0;
    #1;
    check("rs async out_valid", 32'(out_valid), 0);
    check("rs async op", 32'(op), 0);
    check("rs async in_ready", 32'(in_ready), 0);
    check("rs async cnt", 32'(illegal_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rs no op7[%0d]", i), 32'(out_valid), 0);
    end
    in_valid = 1'b1; ALUop = 2'd0; func = 5'd0;
    tick();
    in_valid = 1'b0;
    check("rs resume op", 32'(op), 2);
    check("rs resume last", 32'(op_last), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have parameter FUNC_W, default 4: width of func field, legal range 3..8.
REQ-002 The block SHALL have parameter OP_W, default 4: width of ALU op code, minimum 4.
REQ-003 The block SHALL have parameter DEPTH, default 4: micro-op queue entries, power of 2, minimum 2.
REQ-004 The block SHALL have parameter CNT_W, default 8: width of the illegal-instruction counter.
REQ-005 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1: request present.
REQ-008 The block SHALL have port in_ready, output, 1: request accepted when in_valid && in_ready at a clock edge.
REQ-009 The block SHALL have port ALUop, input, 2: class select (0 add, 1 subtract, 2 use func, 3 or).
REQ-010 The block SHALL have port func, input, FUNC_W: function field, used only when ALUop==2.
REQ-011 The block SHALL have port out_valid, output, 1: queue head holds a valid micro-op.
REQ-012 The block SHALL have port out_ready, input, 1: consumer takes the head when out_valid && out_ready at a clock edge.
REQ-013 The block SHALL have port op, output, OP_W: head micro-op code.
REQ-014 The block SHALL have port op_last, output, 1: head is the final micro-op of its instruction.
REQ-015 The block SHALL have port illegal_cnt, output, CNT_W: saturating count of illegal func values accepted.

Function
REQ-016 The block SHALL decode ALUop 0 -> op 2, ALUop 1 -> op 3, and ALUop 3 -> op 4, each as one micro-op.
REQ-017 For ALUop 2, the block SHALL decode func 0 -> 2 (add), 1 -> 3 (sub), 2 -> 0 (and), 3 -> 4 (or), 4 -> 5 (nor), 5 -> 1 (nand), and 6 -> 6 (xor), each as a single micro-op.
REQ-018 For ALUop 2 with func 7 (slt), the block SHALL enqueue two micro-ops in order: 3 (sub) with op_last=0, then 7 (set-on-sign) with op_last=1.
REQ-019 For ALUop 2 with func >= 8, the block SHALL enqueue one micro-op of value all-ones (NOP) with op_last=1 and increment illegal_cnt, saturating at 2^CNT_W-1.
REQ-020 All single micro-ops SHALL carry op_last=1.
REQ-021 The queue SHALL be a DEPTH-entry FIFO of {op, op_last}; op, op_last and out_valid SHALL be driven from registered queue state only, with out_valid=1 iff the queue is non-empty.
REQ-022 Latency SHALL be one cycle: a request accepted at edge N into an empty queue SHALL appear on op at edge N+1.
REQ-023 The block SHALL implement a two-state FSM: IDLE and SECOND.
REQ-024 In IDLE, in_ready SHALL equal (queue not full); it SHALL be a registered-state function with no combinational path from out_ready.
REQ-025 On accepting slt in IDLE, the block SHALL push micro-op 3 and go to SECOND; in SECOND, in_ready SHALL be 0.
REQ-026 In SECOND, the block SHALL push micro-op 7 at the first edge where the queue is not full, then return to IDLE.
REQ-027 On a simultaneous push and pop, occupancy SHALL be unchanged and ordering preserved; a push SHALL never occur when full and a pop SHALL never occur when empty.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy counter of width log2(DEPTH)+1.
REQ-029 The block SHALL ignore ALUop and func when the request is not accepted.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force: queue empty, out_valid=0, op=0, op_last=0, FSM=IDLE, in_ready=0, illegal_cnt=0.
REQ-031 in_ready SHALL be 1 at the first edge after rst_n deasserts.
REQ-032 A reset asserted mid-operation, including in SECOND, SHALL discard all queued and pending micro-ops, with no partial slt emitted afterwards.

Verification
REQ-033 Directed test, full decode: with out_ready=1, send ALUop 0,1,3, then ALUop 2 with func 0..6 -> op sequence 2,3,4,2,3,0,4,5,1,6, each with op_last=1, each one cycle after acceptance.
REQ-034 Directed test, slt split: send ALUop 2 with func 7 and out_ready=1 -> op 3 (op_last=0), then op 7 (op_last=1) on consecutive cycles; in_ready=0 for one cycle.
REQ-035 Directed test, backpressure: with out_ready=0, send 4 add requests (DEPTH=4) -> in_ready=0 after the 4th; raise out_ready -> four op=2 drain in order and in_ready returns to 1.
REQ-036 Directed test, slt near full: with 3 entries queued and out_ready=0, send slt -> op 3 queued, FSM held in SECOND; pop once -> op 7 pushed the next edge; order preserved.
REQ-037 Directed test, illegal func: with FUNC_W=5 and CNT_W=2, send func 8 five times -> op=4'hF each time; illegal_cnt goes 1,2,3,3,3.
REQ-038 Directed test, reset in SECOND: assert rst_n=0 the cycle after slt acceptance -> out_valid drops to 0 asynchronously; after release, no op 7 appears.
